// File: rtl/sdram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sdram_arbiter                                                    |
// | Brief   : Two-master SDRAM command arbiter with outstanding-read tag FIFO. |
// |           Define SDRAM_ARBITER_FIXED_PRIO_EN for fixed priority (m0 wins). |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module sdram_arbiter #(
  parameter int MAX_PENDING = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [24:0] m0_address,
  input  logic [1:0]  m0_byteenable,
  input  logic [15:0] m0_writedata,
  input  logic        m0_read,
  input  logic        m0_write,
  output logic        m0_waitrequest,
  output logic [15:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic [24:0] m1_address,
  input  logic [1:0]  m1_byteenable,
  input  logic [15:0] m1_writedata,
  input  logic        m1_read,
  input  logic        m1_write,
  output logic        m1_waitrequest,
  output logic [15:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic [24:0] sdr_address,
  output logic [1:0]  sdr_byteenable_n,
  output logic        sdr_chipselect,
  output logic [15:0] sdr_writedata,
  output logic        sdr_read_n,
  output logic        sdr_write_n,
  input  logic [15:0] sdr_readdata,
  input  logic        sdr_readdatavalid,
  input  logic        sdr_waitrequest,
  output logic        rd_orphan_err
);
  localparam int c_ptr_w = $clog2(MAX_PENDING);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(MAX_PENDING);
  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_cmd  = 1'b1;

  logic [0:0]         r_state, w_next_state;
  logic               r_grant, w_next_grant;
  logic               r_tags [MAX_PENDING];
  logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_orphan;

  logic        w_full, w_empty, w_elig0, w_elig1, w_pick;
  logic        w_in_cmd, w_accept, w_push, w_pop;
  logic        w_g_read, w_g_write;
  logic [24:0] w_g_addr;
  logic [1:0]  w_g_be;
  logic [15:0] w_g_wdata;

  assign w_full   = (r_count == c_full);
  assign w_empty  = (r_count == '0);
  // Simultaneous read+write counts as a write, which never needs a tag slot.
  assign w_elig0  = m0_write | (m0_read & ~w_full);
  assign w_elig1  = m1_write | (m1_read & ~w_full);

`ifdef SDRAM_ARBITER_FIXED_PRIO_EN
  assign w_pick = ~w_elig0;
`else
  logic r_last;
  assign w_pick = (w_elig0 & w_elig1) ? ~r_last : w_elig1;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_last <= 1'b1;
    end else if (r_state == c_idle && w_next_state == c_cmd) begin
      r_last <= w_pick;
    end
  end
`endif

  assign w_g_read  = r_grant ? m1_read       : m0_read;
  assign w_g_write = r_grant ? m1_write      : m0_write;
  assign w_g_addr  = r_grant ? m1_address    : m0_address;
  assign w_g_be    = r_grant ? m1_byteenable : m0_byteenable;
  assign w_g_wdata = r_grant ? m1_writedata  : m0_writedata;

  assign w_in_cmd = (r_state == c_cmd);
  assign w_accept = w_in_cmd & ~sdr_waitrequest;
  assign w_push   = w_accept & w_g_read & ~w_g_write;
  assign w_pop    = sdr_readdatavalid & ~w_empty;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= c_idle;
      r_grant <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_grant <= w_next_grant;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_grant = r_grant;
    case (r_state)
      c_idle: begin
        if (w_elig0 | w_elig1) begin
          w_next_state = c_cmd;
          w_next_grant = w_pick;
        end
      end
      c_cmd: begin
        if (!sdr_waitrequest) w_next_state = c_idle;
      end
      default: w_next_state = c_idle;
    endcase
  end

  always_comb begin
    sdr_address      = '0;
    sdr_writedata    = '0;
    sdr_byteenable_n = 2'b11;
    sdr_chipselect   = 1'b0;
    sdr_read_n       = 1'b1;
    sdr_write_n      = 1'b1;
    m0_waitrequest   = 1'b1;
    m1_waitrequest   = 1'b1;
    if (w_in_cmd) begin
      sdr_address      = w_g_addr;
      sdr_writedata    = w_g_wdata;
      sdr_byteenable_n = ~w_g_be;
      sdr_chipselect   = 1'b1;
      sdr_read_n       = ~(w_g_read & ~w_g_write);
      sdr_write_n      = ~w_g_write;
      if (!sdr_waitrequest) begin
        if (r_grant) m1_waitrequest = 1'b0;
        else         m0_waitrequest = 1'b0;
      end
    end
  end

  // Pointers wrap naturally since MAX_PENDING is a power of two.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_orphan <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (sdr_readdatavalid && w_empty) r_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (w_push) r_tags[r_wr_ptr] <= r_grant;
  end

  assign m0_readdata      = sdr_readdata;
  assign m1_readdata      = sdr_readdata;
  assign m0_readdatavalid = w_pop & ~r_tags[r_rd_ptr];
  assign m1_readdatavalid = w_pop &  r_tags[r_rd_ptr];
  assign rd_orphan_err    = r_orphan;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sdram_arbiter                                                 |
// | Brief   : Directed and randomized bench for sdram_arbiter with a           |
// |           transaction-level reference model (grant owner + tag queue).     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_sdram_arbiter;
  localparam int MAXP = 4;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [24:0] m0_address = '0, m1_address = '0;
  logic [1:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic [15:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [15:0] m0_readdata, m1_readdata;
  logic [24:0] sdr_address;
  logic [1:0]  sdr_byteenable_n;
  logic        sdr_chipselect, sdr_read_n, sdr_write_n, rd_orphan_err;
  logic [15:0] sdr_writedata;
  logic [15:0] sdr_readdata = '0;
  logic        sdr_readdatavalid = 1'b0, sdr_waitrequest = 1'b0;

  always #5 clk_clk = ~clk_clk;

  sdram_arbiter #(.MAX_PENDING(MAXP)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_read(m0_read), .m0_write(m0_write), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_read(m1_read), .m1_write(m1_write), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .sdr_address(sdr_address), .sdr_byteenable_n(sdr_byteenable_n),
    .sdr_chipselect(sdr_chipselect), .sdr_writedata(sdr_writedata),
    .sdr_read_n(sdr_read_n), .sdr_write_n(sdr_write_n),
    .sdr_readdata(sdr_readdata), .sdr_readdatavalid(sdr_readdatavalid),
    .sdr_waitrequest(sdr_waitrequest), .rd_orphan_err(rd_orphan_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the bus, who was served last, and the queue of
  // masters still owed read data.
  bit mdl_cmd, mdl_gnt, mdl_last, mdl_orphan;
  int tagq[$];

  function automatic bit is_rd(bit n);
    return n ? (m1_read && !m1_write) : (m0_read && !m0_write);
  endfunction

  function automatic void mdl_reset();
    mdl_cmd = 0; mdl_gnt = 0; mdl_last = 1; mdl_orphan = 0;
    tagq.delete();
  endfunction

  function automatic void mdl_clock();
    int sz;
    bit e0, e1;
    sz = tagq.size();
    if (sdr_readdatavalid) begin
      if (sz > 0) void'(tagq.pop_front());
      else mdl_orphan = 1;
    end
    if (mdl_cmd) begin
      if (!sdr_waitrequest) begin
        if (is_rd(mdl_gnt)) tagq.push_back(int'(mdl_gnt));
        mdl_cmd = 0;
      end
    end else begin
      e0 = m0_write || (m0_read && sz < MAXP);
      e1 = m1_write || (m1_read && sz < MAXP);
      if (e0 || e1) begin
        mdl_cmd = 1;
`ifdef SDRAM_ARBITER_FIXED_PRIO_EN
        mdl_gnt = e0 ? 1'b0 : 1'b1;
`else
        if (e0 && e1) mdl_gnt = (mdl_last == 1'b0) ? 1'b1 : 1'b0;
        else          mdl_gnt = e1;
        mdl_last = mdl_gnt;
`endif
      end
    end
  endfunction

  task automatic tick();
    mdl_clock();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = '0; m1_byteenable = '0;
    sdr_readdatavalid = 0; sdr_waitrequest = 0; sdr_readdata = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset_reset_n = 0;
    mdl_reset();
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    m0_write = 1; m1_read = 1; sdr_readdatavalid = 0;
    reset_reset_n = 0;
    @(posedge clk_clk);
    #2;
    n_cmp++;
    if ({m0_waitrequest, m1_waitrequest, sdr_chipselect, sdr_read_n, sdr_write_n,
         sdr_byteenable_n, m0_readdatavalid, m1_readdatavalid, rd_orphan_err} !== 10'b11_0_11_11_00_0) begin
      n_err++;
      $display("FAIL reset_outputs got=%b exp=%b", {m0_waitrequest, m1_waitrequest, sdr_chipselect,
               sdr_read_n, sdr_write_n, sdr_byteenable_n, m0_readdatavalid, m1_readdatavalid,
               rd_orphan_err}, 10'b11_0_11_11_00_0);
    end
    clear_inputs();
    mdl_reset();
    reset_reset_n = 1;
    tick();
  endtask

  task automatic test_write();
    apply_reset();
    m0_write = 1; m0_address = 25'h0000100; m0_writedata = 16'hBEEF; m0_byteenable = 2'b11;
    #1;
    n_cmp++;
    if ({sdr_chipselect, m0_waitrequest} !== 2'b01) begin
      n_err++; $display("FAIL write_idle got=%b exp=01", {sdr_chipselect, m0_waitrequest});
    end
    tick();
    #1;
    n_cmp++;
    if ({sdr_chipselect, sdr_write_n, sdr_read_n, sdr_byteenable_n, m0_waitrequest, m1_waitrequest} !== 7'b1_0_1_00_0_1) begin
      n_err++;
      $display("FAIL write_cmd got=%b exp=%b", {sdr_chipselect, sdr_write_n, sdr_read_n,
               sdr_byteenable_n, m0_waitrequest, m1_waitrequest}, 7'b1_0_1_00_0_1);
    end
    n_cmp++;
    if (sdr_address !== 25'h0000100 || sdr_writedata !== 16'hBEEF) begin
      n_err++; $display("FAIL write_addr_data got=%h/%h exp=0000100/beef", sdr_address, sdr_writedata);
    end
    tick();
    m0_write = 0;
    #1;
    n_cmp++;
    if ({sdr_chipselect, sdr_write_n, m0_waitrequest} !== 3'b011) begin
      n_err++; $display("FAIL write_done got=%b exp=011", {sdr_chipselect, sdr_write_n, m0_waitrequest});
    end
  endtask

  task automatic test_round_robin();
    int grants[$];
    int expg;
    apply_reset();
    m0_read = 1; m1_read = 1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (sdr_chipselect === 1'b1) begin
        if (m0_waitrequest === 1'b0) grants.push_back(0);
        else if (m1_waitrequest === 1'b0) grants.push_back(1);
      end
      tick();
    end
    clear_inputs();
    n_cmp++;
    if (grants.size() != 4) begin
      n_err++; $display("FAIL rr_grant_count got=%0d exp=4", grants.size());
    end
    for (int k = 0; k < grants.size() && k < 4; k++) begin
`ifdef SDRAM_ARBITER_FIXED_PRIO_EN
      expg = 0;
`else
      expg = k % 2;
`endif
      n_cmp++;
      if (grants[k] != expg) begin
        n_err++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", k, grants[k], expg);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int waited;
    apply_reset();
    acc = 0;
    m1_read = 1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (m1_waitrequest === 1'b0) acc++;
      tick();
    end
    n_cmp++;
    if (acc != MAXP) begin
      n_err++; $display("FAIL full_accept_count got=%0d exp=%0d", acc, MAXP);
    end
    sdr_readdatavalid = 1;
    #1;
    n_cmp++;
    if ({m1_waitrequest, m1_readdatavalid, m0_readdatavalid} !== 3'b110) begin
      n_err++; $display("FAIL full_pop got=%b exp=110", {m1_waitrequest, m1_readdatavalid, m0_readdatavalid});
    end
    tick();
    sdr_readdatavalid = 0;
    waited = 0;
    #1;
    while (m1_waitrequest === 1'b1 && waited < 6) begin
      tick();
      #1;
      waited++;
    end
    n_cmp++;
    if (m1_waitrequest !== 1'b0 || waited != 1) begin
      n_err++; $display("FAIL full_resume got_wait=%b got_cycles=%0d exp_wait=0 exp_cycles=1", m1_waitrequest, waited);
    end
    tick();
    m1_read = 0;
  endtask

  task automatic test_read_order();
    int order[3] = '{0, 1, 0};
    logic [15:0] data[3] = '{16'h1111, 16'h2222, 16'h3333};
    int waited;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      if (order[k] == 1) m1_read = 1; else m0_read = 1;
      waited = 0;
      #1;
      while (((order[k] == 1) ? m1_waitrequest : m0_waitrequest) === 1'b1 && waited < 6) begin
        tick();
        #1;
        waited++;
      end
      n_cmp++;
      if (((order[k] == 1) ? m1_waitrequest : m0_waitrequest) !== 1'b0) begin
        n_err++; $display("FAIL order_issue[%0d] timeout got_wait=1 exp_wait=0", k);
      end
      tick();
      m0_read = 0; m1_read = 0;
    end
    for (int k = 0; k < 3; k++) begin
      sdr_readdatavalid = 1; sdr_readdata = data[k];
      #1;
      n_cmp++;
      if ({m1_readdatavalid, m0_readdatavalid} !== ((order[k] == 1) ? 2'b10 : 2'b01)
          || m0_readdata !== data[k] || m1_readdata !== data[k]) begin
        n_err++;
        $display("FAIL order_return[%0d] got_rdv=%b got_data=%h/%h exp_master=%0d exp_data=%h",
                 k, {m1_readdatavalid, m0_readdatavalid}, m0_readdata, m1_readdata, order[k], data[k]);
      end
      tick();
    end
    sdr_readdatavalid = 0;
    #1;
    n_cmp++;
    if (rd_orphan_err !== 1'b0) begin
      n_err++; $display("FAIL order_no_orphan got=%b exp=0", rd_orphan_err);
    end
  endtask

  task automatic test_orphan();
    apply_reset();
    sdr_readdatavalid = 1;
    #1;
    n_cmp++;
    if ({m0_readdatavalid, m1_readdatavalid, rd_orphan_err} !== 3'b000) begin
      n_err++; $display("FAIL orphan_cycle got=%b exp=000", {m0_readdatavalid, m1_readdatavalid, rd_orphan_err});
    end
    tick();
    sdr_readdatavalid = 0;
    tick(); tick(); tick();
    #1;
    n_cmp++;
    if (rd_orphan_err !== 1'b1) begin
      n_err++; $display("FAIL orphan_sticky got=%b exp=1", rd_orphan_err);
    end
    reset_reset_n = 0;
    #1;
    n_cmp++;
    if (rd_orphan_err !== 1'b0) begin
      n_err++; $display("FAIL orphan_reset got=%b exp=0", rd_orphan_err);
    end
    mdl_reset();
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1;
  endtask

  task automatic test_reset_in_cmd();
    apply_reset();
    m0_read = 1; sdr_waitrequest = 1;
    tick();
    #1;
    n_cmp++;
    if ({sdr_chipselect, sdr_read_n, m0_waitrequest} !== 3'b101) begin
      n_err++; $display("FAIL stall_cmd got=%b exp=101", {sdr_chipselect, sdr_read_n, m0_waitrequest});
    end
    reset_reset_n = 0;
    #1;
    n_cmp++;
    if ({m0_waitrequest, m1_waitrequest, sdr_chipselect, sdr_read_n, sdr_write_n,
         sdr_byteenable_n, rd_orphan_err} !== 8'b11_0_11_11_0) begin
      n_err++;
      $display("FAIL reset_mid_cmd got=%b exp=%b", {m0_waitrequest, m1_waitrequest, sdr_chipselect,
               sdr_read_n, sdr_write_n, sdr_byteenable_n, rd_orphan_err}, 8'b11_0_11_11_0);
    end
    clear_inputs();
    mdl_reset();
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1;
    sdr_readdatavalid = 1;
    #1;
    n_cmp++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      n_err++; $display("FAIL reset_no_push got=%b exp=00", {m0_readdatavalid, m1_readdatavalid});
    end
    tick();
    sdr_readdatavalid = 0;
    #1;
    n_cmp++;
    if (rd_orphan_err !== 1'b1) begin
      n_err++; $display("FAIL reset_inflight_orphan got=%b exp=1", rd_orphan_err);
    end
  endtask

  task automatic test_random();
    logic [1:0]  exp_wait, exp_rdv, be;
    logic [4:0]  exp_ctl;
    logic [24:0] exp_addr;
    logic [15:0] exp_wd;
    bit g, gr, gw;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      m0_read  = ($urandom % 3) == 0;  m0_write = ($urandom % 4) == 0;
      m1_read  = ($urandom % 3) == 0;  m1_write = ($urandom % 4) == 0;
      m0_address = 25'($urandom); m1_address = 25'($urandom);
      m0_writedata = 16'($urandom); m1_writedata = 16'($urandom);
      m0_byteenable = 2'($urandom); m1_byteenable = 2'($urandom);
      sdr_waitrequest = ($urandom % 3) == 0;
      sdr_readdata = 16'($urandom);
      sdr_readdatavalid = (tagq.size() > 0) ? (($urandom % 3) == 0) : (($urandom % 80) == 0);
      #1;
      g  = mdl_gnt;
      gr = is_rd(g);
      gw = g ? m1_write : m0_write;
      be = g ? m1_byteenable : m0_byteenable;
      exp_wait = {!(mdl_cmd && g && !sdr_waitrequest), !(mdl_cmd && !g && !sdr_waitrequest)};
      exp_rdv  = 2'b00;
      if (sdr_readdatavalid && tagq.size() > 0) exp_rdv = (tagq[0] == 1) ? 2'b10 : 2'b01;
      exp_ctl  = mdl_cmd ? {1'b1, !gr, !gw, ~be} : 5'b0_1_1_11;
      exp_addr = mdl_cmd ? (g ? m1_address : m0_address) : 25'd0;
      exp_wd   = mdl_cmd ? (g ? m1_writedata : m0_writedata) : 16'd0;
      n_cmp++;
      if ({m1_waitrequest, m0_waitrequest} !== exp_wait) begin
        n_err++; $display("FAIL rnd_wait cyc=%0d got=%b exp=%b", c, {m1_waitrequest, m0_waitrequest}, exp_wait);
      end
      n_cmp++;
      if ({m1_readdatavalid, m0_readdatavalid} !== exp_rdv) begin
        n_err++; $display("FAIL rnd_rdv cyc=%0d got=%b exp=%b", c, {m1_readdatavalid, m0_readdatavalid}, exp_rdv);
      end
      n_cmp++;
      if ({sdr_chipselect, sdr_read_n, sdr_write_n, sdr_byteenable_n} !== exp_ctl) begin
        n_err++;
        $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", c,
                 {sdr_chipselect, sdr_read_n, sdr_write_n, sdr_byteenable_n}, exp_ctl);
      end
      n_cmp++;
      if (sdr_address !== exp_addr || sdr_writedata !== exp_wd) begin
        n_err++; $display("FAIL rnd_addr_data cyc=%0d got=%h/%h exp=%h/%h", c, sdr_address, sdr_writedata, exp_addr, exp_wd);
      end
      n_cmp++;
      if (m0_readdata !== sdr_readdata || m1_readdata !== sdr_readdata) begin
        n_err++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h", c, m0_readdata, m1_readdata, sdr_readdata);
      end
      n_cmp++;
      if (rd_orphan_err !== mdl_orphan) begin
        n_err++; $display("FAIL rnd_orphan cyc=%0d got=%b exp=%b", c, rd_orphan_err, mdl_orphan);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    mdl_reset();
    test_reset();
    test_write();
    test_round_robin();
    test_backpressure();
    test_read_order();
    test_orphan();
    test_reset_in_cmd();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter MAX_PENDING, default 4, giving the depth of the outstanding-read tag FIFO (power of 2, 2..16).
REQ-002 SHALL have port clk_clk  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port reset_reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have, for N in {0,1}: mN_address input 25, mN_byteenable input 2 (active-high), mN_writedata input 16, mN_read input 1, mN_write input 1.
REQ-005 SHALL have, for N in {0,1}: mN_waitrequest output 1, mN_readdata output 16, mN_readdatavalid output 1.
REQ-006 SHALL have SDRAM-side outputs: sdr_address 25, sdr_byteenable_n 2, sdr_chipselect 1, sdr_writedata 16, sdr_read_n 1, sdr_write_n 1.
REQ-007 SHALL have SDRAM-side inputs: sdr_readdata 16, sdr_readdatavalid 1, sdr_waitrequest 1.
REQ-008 SHALL have port rd_orphan_err  output  1  sticky flag for readdatavalid received with no pending read.

Function
REQ-009 SHALL implement FSM states IDLE and CMD.
REQ-010 In IDLE, a master is requesting when mN_read or mN_write is 1; a read request is eligible only when the tag FIFO is not full.
REQ-011 In IDLE with at least one eligible request, the FSM SHALL register the grant and enter CMD next cycle; with none, it SHALL stay in IDLE.
REQ-012 Both masters eligible: round-robin arbitration SHALL grant the master not granted last (last-grant pointer resets to 1, so master 0 wins first).
REQ-013 In CMD, sdr_* SHALL combinationally mirror the granted master: sdr_byteenable_n = ~mN_byteenable, sdr_chipselect = 1, and sdr_read_n/sdr_write_n = inverted mN_read/mN_write.
REQ-014 Outside CMD: sdr_chipselect=0, sdr_read_n=1, sdr_write_n=1, sdr_byteenable_n=2'b11; address and data are don't-care and driven 0.
REQ-015 mN_waitrequest SHALL be 0 only in CMD for the granted master while sdr_waitrequest=0; otherwise it SHALL be 1.
REQ-016 Acceptance = CMD and sdr_waitrequest=0; on acceptance the FSM SHALL return to IDLE next cycle; one transfer per grant; minimum 2 cycles per command.
REQ-017 An accepted read SHALL push the granted master ID into the tag FIFO in the acceptance cycle.
REQ-018 sdr_readdatavalid=1 SHALL pop the FIFO head and assert that master's mN_readdatavalid combinationally in the same cycle; sdr_readdata SHALL be driven to both mN_readdata.
REQ-019 Simultaneous push and pop SHALL be legal at any occupancy, including full; the count is unchanged.
REQ-020 sdr_readdatavalid with an empty FIFO SHALL assert no mN_readdatavalid and SHALL set rd_orphan_err until reset.
REQ-021 FIFO pointers SHALL wrap modulo MAX_PENDING; the count width is clog2(MAX_PENDING)+1.
REQ-022 A master asserting both mN_read and mN_write SHALL be treated as a write.

Reset
REQ-023 reset_reset_n=0 SHALL immediately force: FSM to IDLE, last-grant to 1, FIFO empty, rd_orphan_err=0, mN_waitrequest=1, mN_readdatavalid=0, sdr_chipselect=0, sdr_read_n=1, sdr_write_n=1.
REQ-024 Reset mid-CMD SHALL abort the command without acceptance; read data still in flight after reset SHALL be flagged as orphan.

Configuration
REQ-025 With macro SDRAM_ARBITER_FIXED_PRIO_EN defined, master 0 SHALL always win contention and the last-grant pointer SHALL be omitted.
REQ-026 Without SDRAM_ARBITER_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-012.

Verification
REQ-027 m0 write addr 0x0000100 data 0xBEEF, sdr_waitrequest=0 -> sdr_write_n=0 for one cycle in CMD with sdr_byteenable_n=2'b00; m0_waitrequest=0 that cycle.
REQ-028 m0 and m1 reading continuously -> grants alternate 0,1,0,1 (round-robin build); the fixed-priority build grants only m0.
REQ-029 MAX_PENDING=4, m1 issues 5 reads with no readdatavalid -> 4 accepted; the 5th holds m1_waitrequest=1 until one readdatavalid, then is accepted.
REQ-030 Reads accepted in order m0,m1,m0; return data 0x1111,0x2222,0x3333 -> m0 gets 0x1111 and 0x3333, m1 gets 0x2222.
REQ-031 sdr_readdatavalid with an empty FIFO -> rd_orphan_err=1 and stays 1 until reset_reset_n=0.
REQ-032 Reset asserted in CMD with sdr_waitrequest=1 -> outputs at reset values immediately; no acceptance or push occurs.
